load_store_unit: RTL

- Parametrised multi-cycle load/store unit for the ARM-subset CPU core.
- Replaces the single-cycle memory-address register and r_not_w logic inside the core.
- Accepts one LDR/STR (word or byte) request at a time and computes the effective address with pre/post-indexing and U-bit add/subtract.
- Drives a wait-state-capable memory handshake and returns load data plus an optional base-register writeback to the register-writeback stage.

---
 rtl/load_store_unit_pkg.sv | 26 ++
 rtl/lsu_byte_lane.sv | 50 +++++
 rtl/load_store_unit.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_pkg.sv
// -----------------------------------------------------------------------------
// load_store_unit_pkg
// Shared definitions for the load/store unit:
//   - FSM state encodings (LSU_IDLE / LSU_ACCESS / LSU_RESP)
//   - byte-lane count and lane-index width derivations from the data width
//   - default watchdog limit used when LSU_TIMEOUT_EN is defined
// -----------------------------------------------------------------------------
package load_store_unit_pkg;

    localparam logic [1:0] LSU_IDLE   = 2'd0;
    localparam logic [1:0] LSU_ACCESS = 2'd1;
    localparam logic [1:0] LSU_RESP   = 2'd2;

    localparam int LSU_TIMEOUT_DEFAULT = 255;

    // Number of byte lanes on a data bus of the given width.
    function automatic int lsu_lane_count(input int data_w);
        return data_w / 8;
    endfunction

    // Width of a byte-lane index (address low bits selecting the lane).
    function automatic int lsu_lane_idx_w(input int data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// -----------------------------------------------------------------------------
// lsu_byte_lane
// Purely combinational byte-lane steering for the load/store unit.
//   lane        in   byte-lane index (address low bits)
//   store_byte  in   byte to be stored
//   rdata       in   full-width read data from memory
//   be          out  one-hot byte enable at the lane
//   wdata       out  store byte replicated across every lane
//   load_data   out  little-endian lane select, zero-extended
// Parameter: DATA_W (multiple of 8, minimum 16).
// -----------------------------------------------------------------------------
module lsu_byte_lane
    import load_store_unit_pkg::*;
#(
    parameter int DATA_W = 32
)(
    input  logic [lsu_lane_idx_w(DATA_W)-1:0] lane,
    input  logic [7:0]                        store_byte,
    input  logic [DATA_W-1:0]                 rdata,
    output logic [lsu_lane_count(DATA_W)-1:0] be,
    output logic [DATA_W-1:0]                 wdata,
    output logic [DATA_W-1:0]                 load_data
);

    localparam int NL = lsu_lane_count(DATA_W);
    localparam int LW = lsu_lane_idx_w(DATA_W);

    logic [7:0] sel_byte_s;

    // Decode the lane into a one-hot enable and pick the matching read byte.
    always_comb begin
        be         = {NL{1'b0}};
        sel_byte_s = 8'h00;
        for (int i = 0; i < NL; i++) begin
            if (lane == LW'(i)) begin
                be[i]      = 1'b1;
                sel_byte_s = rdata[i*8 +: 8];
            end else begin
                be[i]      = 1'b0;
            end
        end
    end

    // Replicate the store byte so memory sees it on whichever lane is enabled.
    always_comb begin
        wdata     = {NL{store_byte}};
        load_data = {{(DATA_W-8){1'b0}}, sel_byte_s};
    end

endmodule

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// Multi-cycle LDR/STR unit (word or byte) for the ARM-subset core. Accepts one
// request at a time, computes the effective address (pre/post index, U-bit
// add/subtract), runs a wait-state-capable memory handshake and returns load
// data plus optional base-register writeback.
//
// Ports:
//   clk_i, reset_i                 clock, asynchronous active-high reset
//   req_valid_i / req_ready_o      request handshake
//   load_i up_i pre_i wb_i byte_i  L/U/P/W/B instruction bits
//   rd_i, base_i, offset_i         Rd index, Rn value, 12-bit immediate
//   store_data_i                   Rd value for stores
//   mem_req_o .. mem_wdata_o       memory request, held stable until ack
//   mem_ack_i, mem_rdata_i         memory completion and read data
//   resp_valid_o .. fault_o        one-cycle completion to writeback stage
//
// Configuration macro: LSU_TIMEOUT_EN enables a watchdog that aborts an access
// after TIMEOUT cycles without ack and reports a fault.
// -----------------------------------------------------------------------------
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int OFF_W   = 12,
    parameter int TIMEOUT = LSU_TIMEOUT_DEFAULT
)(
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic                load_i,
    input  logic                up_i,
    input  logic                pre_i,
    input  logic                wb_i,
    input  logic                byte_i,
    input  logic [3:0]          rd_i,
    input  logic [ADDR_W-1:0]   base_i,
    input  logic [OFF_W-1:0]    offset_i,
    input  logic [DATA_W-1:0]   store_data_i,
    output logic                mem_req_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic                mem_r_not_w_o,
    output logic [DATA_W/8-1:0] mem_be_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    input  logic                mem_ack_i,
    input  logic [DATA_W-1:0]   mem_rdata_i,
    output logic                resp_valid_o,
    output logic [3:0]          resp_rd_o,
    output logic [DATA_W-1:0]   load_data_o,
    output logic                load_we_o,
    output logic                base_we_o,
    output logic [ADDR_W-1:0]   base_wb_o,
    output logic                fault_o
);

    localparam int NL = lsu_lane_count(DATA_W);
    localparam int LW = lsu_lane_idx_w(DATA_W);

    // FSM and captured request fields
    logic [1:0]        state_r;
    logic              load_r;
    logic              pre_r;
    logic              wb_r;
    logic              byte_r;
    logic [3:0]        rd_r;
    logic [ADDR_W-1:0] eff_r;
    logic [LW-1:0]     lane_r;

    // Registered outputs
    logic              req_ready_r;
    logic              mem_req_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic              mem_rnw_r;
    logic [NL-1:0]     mem_be_r;
    logic [DATA_W-1:0] mem_wdata_r;
    logic              resp_valid_r;
    logic [3:0]        resp_rd_r;
    logic [DATA_W-1:0] load_data_r;
    logic              load_we_r;
    logic              base_we_r;
    logic [ADDR_W-1:0] base_wb_r;
    logic              fault_r;

    // Combinational request decode
    logic [ADDR_W-1:0] off_ext_s;
    logic [ADDR_W-1:0] eff_s;
    logic [ADDR_W-1:0] addr_s;
    logic [LW-1:0]     req_lane_s;
    logic              misaligned_s;
    logic [LW-1:0]     bl_lane_s;
    logic [NL-1:0]     bl_be_s;
    logic [DATA_W-1:0] bl_wdata_s;
    logic [DATA_W-1:0] bl_load_s;
    logic              timeout_hit_s;

    // Effective address, issued address and word-alignment check.
    always_comb begin
        off_ext_s = ADDR_W'(offset_i);
        if (up_i) begin
            eff_s = base_i + off_ext_s;
        end else begin
            eff_s = base_i - off_ext_s;
        end
        if (pre_i) begin
            addr_s = eff_s;
        end else begin
            addr_s = base_i;
        end
        req_lane_s   = addr_s[LW-1:0];
        misaligned_s = !byte_i && (req_lane_s != {LW{1'b0}});
    end

    // The lane steering is shared: the incoming address drives it while idle
    // (store enables/data), the captured lane drives it during the access
    // (load byte select).
    always_comb begin
        if (state_r == LSU_IDLE) begin
            bl_lane_s = req_lane_s;
        end else begin
            bl_lane_s = lane_r;
        end
    end

    lsu_byte_lane #(
        .DATA_W (DATA_W)
    ) u_byte_lane (
        .lane       (bl_lane_s),
        .store_byte (store_data_i[7:0]),
        .rdata      (mem_rdata_i),
        .be         (bl_be_s),
        .wdata      (bl_wdata_s),
        .load_data  (bl_load_s)
    );

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    logic [CNT_W-1:0] wdog_cnt_r;

    // Watchdog: cleared while idle (so it starts at zero on entry to ACCESS),
    // counts each ACCESS cycle that passes without an ack.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wdog_cnt_r <= {CNT_W{1'b0}};
        end else if (state_r == LSU_IDLE) begin
            wdog_cnt_r <= {CNT_W{1'b0}};
        end else if ((state_r == LSU_ACCESS) && !mem_ack_i && !timeout_hit_s) begin
            wdog_cnt_r <= wdog_cnt_r + CNT_W'(1'b1);
        end
    end

    assign timeout_hit_s = (state_r == LSU_ACCESS) && (wdog_cnt_r == CNT_W'(TIMEOUT));
`else
    // TIMEOUT has no role when the watchdog is compiled out.
    logic [31:0] timeout_unused_s;
    assign timeout_unused_s = TIMEOUT;
    assign timeout_hit_s    = 1'b0;
`endif

    // Main FSM: request capture, memory handshake and one-cycle response.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r      <= LSU_IDLE;
            load_r       <= 1'b0;
            pre_r        <= 1'b0;
            wb_r         <= 1'b0;
            byte_r       <= 1'b0;
            rd_r         <= 4'h0;
            eff_r        <= {ADDR_W{1'b0}};
            lane_r       <= {LW{1'b0}};
            req_ready_r  <= 1'b1;
            mem_req_r    <= 1'b0;
            mem_addr_r   <= {ADDR_W{1'b0}};
            mem_rnw_r    <= 1'b1;
            mem_be_r     <= {NL{1'b0}};
            mem_wdata_r  <= {DATA_W{1'b0}};
            resp_valid_r <= 1'b0;
            resp_rd_r    <= 4'h0;
            load_data_r  <= {DATA_W{1'b0}};
            load_we_r    <= 1'b0;
            base_we_r    <= 1'b0;
            base_wb_r    <= {ADDR_W{1'b0}};
            fault_r      <= 1'b0;
        end else begin
            case (state_r)
                LSU_IDLE: begin
                    if (req_valid_i) begin
                        load_r      <= load_i;
                        pre_r       <= pre_i;
                        wb_r        <= wb_i;
                        byte_r      <= byte_i;
                        rd_r        <= rd_i;
                        eff_r       <= eff_s;
                        lane_r      <= req_lane_s;
                        req_ready_r <= 1'b0;
                        if (misaligned_s) begin
                            // Misaligned word: fault straight away, no bus cycle.
                            state_r      <= LSU_RESP;
                            resp_valid_r <= 1'b1;
                            resp_rd_r    <= rd_i;
                            load_data_r  <= {DATA_W{1'b0}};
                            load_we_r    <= 1'b0;
                            base_we_r    <= 1'b0;
                            base_wb_r    <= eff_s;
                            fault_r      <= 1'b1;
                        end else begin
                            state_r     <= LSU_ACCESS;
                            mem_req_r   <= 1'b1;
                            mem_addr_r  <= addr_s;
                            mem_rnw_r   <= load_i;
                            mem_be_r    <= byte_i ? bl_be_s : {NL{1'b1}};
                            mem_wdata_r <= byte_i ? bl_wdata_s : store_data_i;
                        end
                    end
                end
                LSU_ACCESS: begin
                    if (mem_ack_i) begin
                        state_r      <= LSU_RESP;
                        mem_req_r    <= 1'b0;
                        resp_valid_r <= 1'b1;
                        resp_rd_r    <= rd_r;
                        if (load_r) begin
                            load_data_r <= byte_r ? bl_load_s : mem_rdata_i;
                        end else begin
                            load_data_r <= {DATA_W{1'b0}};
                        end
                        load_we_r    <= load_r;
                        // Post-index always writes back; pre-index only with W.
                        base_we_r    <= !pre_r || wb_r;
                        base_wb_r    <= eff_r;
                        fault_r      <= 1'b0;
                    end else if (timeout_hit_s) begin
                        state_r      <= LSU_RESP;
                        mem_req_r    <= 1'b0;
                        resp_valid_r <= 1'b1;
                        resp_rd_r    <= rd_r;
                        load_data_r  <= {DATA_W{1'b0}};
                        load_we_r    <= 1'b0;
                        base_we_r    <= 1'b0;
                        base_wb_r    <= eff_r;
                        fault_r      <= 1'b1;
                    end
                end
                LSU_RESP: begin
                    state_r      <= LSU_IDLE;
                    req_ready_r  <= 1'b1;
                    resp_valid_r <= 1'b0;
                    load_we_r    <= 1'b0;
                    base_we_r    <= 1'b0;
                    fault_r      <= 1'b0;
                end
                default: begin
                    state_r      <= LSU_IDLE;
                    req_ready_r  <= 1'b1;
                    mem_req_r    <= 1'b0;
                    resp_valid_r <= 1'b0;
                    load_we_r    <= 1'b0;
                    base_we_r    <= 1'b0;
                    fault_r      <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready_o   = req_ready_r;
    assign mem_req_o     = mem_req_r;
    assign mem_addr_o    = mem_addr_r;
    assign mem_r_not_w_o = mem_rnw_r;
    assign mem_be_o      = mem_be_r;
    assign mem_wdata_o   = mem_wdata_r;
    assign resp_valid_o  = resp_valid_r;
    assign resp_rd_o     = resp_rd_r;
    assign load_data_o   = load_data_r;
    assign load_we_o     = load_we_r;
    assign base_we_o     = base_we_r;
    assign base_wb_o     = base_wb_r;
    assign fault_o       = fault_r;

endmodule
